wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//  Owns the single register-file write port downstream of the writeback mux.
//  Arbitrates between the in-order pipeline WB result and out-of-band results
//    from a long-latency unit (mul/div, AXI load return).
//  Unit results are queued in a small FIFO; WAW order is kept by killing queued entries.
//  A starvation counter forces a one-cycle pipeline stall so the queue drains.
// PARAMETERS
//  DEPTH         2   unit-result FIFO entries (power of 2, >=2)
//  STARVE_LIMIT  8   cycles FIFO head may wait before pipe_stall asserts
//  XLEN          64  data width
// PORTS
//  clk         in   1     clock
//  rst         in   1     synchronous reset, active-high
//  pipe_wen    in   1     pipeline WB wants to write this cycle
//  pipe_rd     in   5     pipeline destination register
//  pipe_data   in   XLEN  pipeline write data (wb mux output)
//  unit_valid  in   1     unit result valid
//  unit_ready  out  1     FIFO can accept (count < DEPTH)
//  unit_rd     in   5     unit destination register
//  unit_data   in   XLEN  unit result
//  pipe_stall  out  1     hold WB stage this cycle (combinational)
//  rf_wen      out  1     regfile write enable (registered)
//  rf_waddr    out  5     regfile write address (registered)
//  rf_wdata    out  XLEN  regfile write data (registered)
//  fifo_cnt    out  $clog2(DEPTH)+1  live entry count (debug/perf)
// BEHAVIOUR
//  Reset (clk edge with rst=1): rf_wen=0, rf_waddr=0, rf_wdata=0, FIFO empty, fifo_cnt=0,
//    starve_cnt=0; pipe_stall=0 and unit_ready=1 while FIFO empty. rst mid-op drops all queued entries.
//  Effective pipe request: p = pipe_wen & ~pipe_stall & (pipe_rd != 0).
//  Grant per cycle: p wins; else the valid FIFO head; else idle (rf_wen<=0 next cycle).
//  Output latency: grant in cycle N -> rf_wen/waddr/wdata = granted write in cycle N+1.
//  Enqueue: unit_valid & unit_ready; unit_rd==0 is accepted and discarded (no slot).
//  unit_ready = (fifo_cnt < DEPTH); no enqueue-while-full even with same-cycle dequeue.
//  Each entry carries a live bit; dead entries pop without a write, with no extra bubble.
//  WAW kill: when p, every queued entry with rd==pipe_rd goes dead; an entry enqueued in the
//    same cycle with unit_rd==pipe_rd is enqueued dead (unit instr is always the older one).
//  Dequeue: head pops when granted or dead; fifo_cnt counts live+dead slots until popped.
//  starve_cnt: +1 per cycle a live head is denied by p; 0 on head pop or FIFO empty; saturates.
//  pipe_stall = live head & (starve_cnt == STARVE_LIMIT); WB stage holds its instruction and
//    re-presents it next cycle; head is granted that cycle, counter clears.
//  Simultaneous enqueue to empty FIFO + no p: entry is written to FIFO; drains next cycle
//    (see CONFIGURATION for bypass).
//  Pointers wrap modulo DEPTH; full/empty from fifo_cnt, never from pointer compare alone.
// CONFIGURATION
//  WB_BYPASS_EN defined: if FIFO empty, no p, unit_valid & unit_rd!=0, the unit result is granted
//    directly in the enqueue cycle (not stored); rf_* shows it next cycle (1-cycle latency).
//  WB_BYPASS_EN undefined: every unit result goes through the FIFO; min latency 2 cycles.
// TESTING
//  1. Reset, pipe_wen=1 rd=5 data=0xAA for 1 cycle -> next cycle rf_wen=1 waddr=5 wdata=0xAA.
//  2. Idle pipe, unit_valid rd=7 data=0x1234 in cycle 0 -> rf write rd=7 in cycle 2 (cycle 1 with
//     WB_BYPASS_EN); fifo_cnt back to 0.
//  3. Fill: unit_valid 3 cycles (rd=1,2,3) with pipe_wen=1 rd=9 each cycle -> unit_ready=0 after 2nd
//     accept; 3rd held until a slot frees; writes rd=1,2 drain in order after pipe goes idle.
//  4. WAW: queue rd=4, then pipe_wen rd=4 data=0x55 -> rf gets 0x55 only; rd=4 unit write never
//     appears; same-cycle enqueue rd=4 + pipe rd=4 -> only pipe write.
//  5. Starvation: queue rd=6, pipe_wen=1 every cycle (rd=8) -> pipe_stall=1 exactly in 9th cycle,
//     rd=6 written next cycle, stall drops, pipe rd=8 write resumes.
//  6. rst=1 with 2 entries queued and rf_wen=1 -> next cycle rf_wen=0, fifo_cnt=0, no later writes.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: owns the single register-file write port. Arbitrates the in-order
// pipeline writeback against queued long-latency unit results, keeps WAW order by
// killing stale queued entries, and forces a one-cycle stall when the queue head starves.
// Optional feature macro: WB_BYPASS_EN (unit result written directly when the queue is empty).
`default_nettype none

module wb_arbiter #(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned XLEN         = 64
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_pipe_wen,
  input  logic [4:0]                  i_pipe_rd,
  input  logic [XLEN-1:0]             i_pipe_data,
  input  logic                        i_unit_valid,
  output logic                        o_unit_ready,
  input  logic [4:0]                  i_unit_rd,
  input  logic [XLEN-1:0]             i_unit_data,
  output logic                        o_pipe_stall,
  output logic                        o_rf_wen,
  output logic [4:0]                  o_rf_waddr,
  output logic [XLEN-1:0]             o_rf_wdata,
  output logic [$clog2(DEPTH):0]      o_fifo_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]      r_rd   [DEPTH];
  logic [XLEN-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_live;
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_cnt;
  logic [SW-1:0]   r_starve;
  logic            r_rf_wen;
  logic [4:0]      r_rf_waddr;
  logic [XLEN-1:0] r_rf_wdata;

  logic w_empty;
  logic w_head_live;
  logic w_stall;
  logic w_p;
  logic w_ready;
  logic w_acc;
  logic w_byp;
  logic w_enq;
  logic w_enq_live;
  logic w_head_grant;
  logic w_pop;

  // Queue status, arbitration and stall decisions.
  assign w_empty      = (r_cnt == CW'(0));
  assign w_head_live  = ~w_empty & r_live[r_rptr];
  assign w_stall      = w_head_live & (r_starve == SW'(STARVE_LIMIT));
  assign w_p          = i_pipe_wen & ~w_stall & (i_pipe_rd != 5'd0);
  assign w_ready      = (r_cnt < CW'(DEPTH));
  assign w_acc        = i_unit_valid & w_ready & (i_unit_rd != 5'd0);
`ifdef WB_BYPASS_EN
  assign w_byp        = w_empty & ~w_p & i_unit_valid & (i_unit_rd != 5'd0);
`else
  assign w_byp        = 1'b0;
`endif
  assign w_enq        = w_acc & ~w_byp;
  // The unit instruction is always older, so a same-cycle match with the pipe is stale.
  assign w_enq_live   = ~(w_p & (i_unit_rd == i_pipe_rd));
  assign w_head_grant = ~w_p & w_head_live;
  // Dead heads pop even while the pipe holds the port, so they cost no bubble.
  assign w_pop        = ~w_empty & (w_head_grant | ~r_live[r_rptr]);

  assign o_unit_ready = w_ready;
  assign o_pipe_stall = w_stall;
  assign o_rf_wen     = r_rf_wen;
  assign o_rf_waddr   = r_rf_waddr;
  assign o_rf_wdata   = r_rf_wdata;
  assign o_fifo_cnt   = r_cnt;

  // Queue payload storage; validity is tracked by the counter and live bits.
  always_ff @(posedge i_clk) begin
    if (w_enq) begin
      r_rd[r_wptr]   <= i_unit_rd;
      r_data[r_wptr] <= i_unit_data;
    end
  end

  // Queue control: pointers, count, live bits with WAW kill, starvation counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_cnt    <= '0;
      r_live   <= '0;
      r_starve <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (w_p && (r_rd[i] == i_pipe_rd)) r_live[i] <= 1'b0;
      end
      if (w_enq) begin
        r_live[r_wptr] <= w_enq_live;
        r_wptr         <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_cnt <= r_cnt + CW'(w_enq) - CW'(w_pop);
      if (w_pop || w_empty) begin
        r_starve <= '0;
      end else if (w_head_live && w_p && (r_starve != SW'(STARVE_LIMIT))) begin
        r_starve <= r_starve + SW'(1);
      end
    end
  end

  // Registered write port: pipe first, then queue head, then (optionally) bypass.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rf_wen   <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else if (w_p) begin
      r_rf_wen   <= 1'b1;
      r_rf_waddr <= i_pipe_rd;
      r_rf_wdata <= i_pipe_data;
    end else if (w_head_grant) begin
      r_rf_wen   <= 1'b1;
      r_rf_waddr <= r_rd[r_rptr];
      r_rf_wdata <= r_data[r_rptr];
    end else if (w_byp) begin
      r_rf_wen   <= 1'b1;
      r_rf_waddr <= i_unit_rd;
      r_rf_wdata <= i_unit_data;
    end else begin
      r_rf_wen   <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a per-cycle vector table plus hand-written
// sequences for queue fill, unit latency and starvation.
module tb_wb_arbiter;

  localparam int unsigned XLEN = 64;

  logic            clk;
  logic            rst;
  logic            pipe_wen;
  logic [4:0]      pipe_rd;
  logic [XLEN-1:0] pipe_data;
  logic            unit_valid;
  logic            unit_ready;
  logic [4:0]      unit_rd;
  logic [XLEN-1:0] unit_data;
  logic            pipe_stall;
  logic            rf_wen;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [1:0]      fifo_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(8), .XLEN(XLEN)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_pipe_wen   (pipe_wen),
    .i_pipe_rd    (pipe_rd),
    .i_pipe_data  (pipe_data),
    .i_unit_valid (unit_valid),
    .o_unit_ready (unit_ready),
    .i_unit_rd    (unit_rd),
    .i_unit_data  (unit_data),
    .o_pipe_stall (pipe_stall),
    .o_rf_wen     (rf_wen),
    .o_rf_waddr   (rf_waddr),
    .o_rf_wdata   (rf_wdata),
    .o_fifo_cnt   (fifo_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        pw;
    logic [4:0]  prd;
    logic [63:0] pd;
    logic        uv;
    logic [4:0]  urd;
    logic [63:0] ud;
    logic        e_wen;
    logic [4:0]  e_addr;
    logic [63:0] e_data;
    logic [1:0]  e_cnt;
    logic        e_ready;
    logic        e_stall;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic r, input logic pw, input logic [4:0] prd,
                              input logic [63:0] pd, input logic uv, input logic [4:0] urd,
                              input logic [63:0] ud, input logic ew, input logic [4:0] ea,
                              input logic [63:0] ed, input logic [1:0] ec, input logic er,
                              input logic es);
    vec_t v;
    v.rst = r; v.pw = pw; v.prd = prd; v.pd = pd; v.uv = uv; v.urd = urd; v.ud = ud;
    v.e_wen = ew; v.e_addr = ea; v.e_data = ed; v.e_cnt = ec; v.e_ready = er; v.e_stall = es;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic pw, input logic [4:0] prd, input logic [63:0] pd,
                       input logic uv, input logic [4:0] urd, input logic [63:0] ud);
    rst = r; pipe_wen = pw; pipe_rd = prd; pipe_data = pd;
    unit_valid = uv; unit_rd = urd; unit_data = ud;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare all outputs; address/data only matter when a write is shown.
  task automatic chk_out(input string tag, input logic ew, input logic [4:0] ea,
                         input logic [63:0] ed, input logic [1:0] ec, input logic er,
                         input logic es);
    chk({tag, ".wen"}, 64'(rf_wen), 64'(ew));
    if (ew) begin
      chk({tag, ".waddr"}, 64'(rf_waddr), 64'(ea));
      chk({tag, ".wdata"}, rf_wdata, ed);
    end
    chk({tag, ".cnt"},   64'(fifo_cnt), 64'(ec));
    chk({tag, ".ready"}, 64'(unit_ready), 64'(er));
    chk({tag, ".stall"}, 64'(pipe_stall), 64'(es));
  endtask

  initial begin
    drive(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);

    //             rst pw prd    pd        uv urd    ud        wen addr   data      cnt ready stall
    vecs[0]  = mk(1, 0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    2'd0, 1, 0);
    vecs[1]  = mk(0, 1, 5'd5,  64'hAA,   0, 5'd0,  64'h0,    1, 5'd5,  64'hAA,   2'd0, 1, 0);
    vecs[2]  = mk(0, 0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    2'd0, 1, 0);
    vecs[3]  = mk(0, 1, 5'd9,  64'h99,   1, 5'd4,  64'h44,   1, 5'd9,  64'h99,   2'd1, 1, 0);
    vecs[4]  = mk(0, 1, 5'd4,  64'h55,   0, 5'd0,  64'h0,    1, 5'd4,  64'h55,   2'd1, 1, 0);
    vecs[5]  = mk(0, 0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    2'd0, 1, 0);
    vecs[6]  = mk(0, 1, 5'd4,  64'h66,   1, 5'd4,  64'h77,   1, 5'd4,  64'h66,   2'd1, 1, 0);
    vecs[7]  = mk(0, 0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    2'd0, 1, 0);
    vecs[8]  = mk(0, 0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    2'd0, 1, 0);
    vecs[9]  = mk(0, 1, 5'd0,  64'h3,    1, 5'd0,  64'h1,    0, 5'd0,  64'h0,    2'd0, 1, 0);
    vecs[10] = mk(0, 1, 5'd10, 64'hA0,   1, 5'd11, 64'hB1,   1, 5'd10, 64'hA0,   2'd1, 1, 0);
    vecs[11] = mk(0, 1, 5'd12, 64'hA2,   1, 5'd13, 64'hB3,   1, 5'd12, 64'hA2,   2'd2, 0, 0);
    vecs[12] = mk(1, 1, 5'd14, 64'hA4,   1, 5'd15, 64'hB5,   0, 5'd0,  64'h0,    2'd0, 1, 0);
    vecs[13] = mk(0, 0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    2'd0, 1, 0);
    vecs[14] = mk(0, 0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    2'd0, 1, 0);
    vecs[15] = mk(0, 1, 5'd20, 64'h1,    1, 5'd21, 64'h2,    1, 5'd20, 64'h1,    2'd1, 1, 0);
    vecs[16] = mk(0, 1, 5'd21, 64'h3,    0, 5'd0,  64'h0,    1, 5'd21, 64'h3,    2'd1, 1, 0);
    vecs[17] = mk(0, 1, 5'd22, 64'h4,    0, 5'd0,  64'h0,    1, 5'd22, 64'h4,    2'd0, 1, 0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].pw, vecs[i].prd, vecs[i].pd, vecs[i].uv, vecs[i].urd, vecs[i].ud);
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].e_wen, vecs[i].e_addr, vecs[i].e_data,
              vecs[i].e_cnt, vecs[i].e_ready, vecs[i].e_stall);
    end

    // Unit result with idle pipe: FIFO path, or direct grant when bypass is built in.
    drive(0, 0, 5'd0, 64'h0, 1, 5'd7, 64'h1234);
    step();
`ifdef WB_BYPASS_EN
    chk_out("unit_lat.c1", 1, 5'd7, 64'h1234, 2'd0, 1, 0);
    drive(0, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0);
    step();
    chk_out("unit_lat.c2", 0, 5'd0, 64'h0, 2'd0, 1, 0);
`else
    chk_out("unit_lat.c1", 0, 5'd0, 64'h0, 2'd1, 1, 0);
    drive(0, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0);
    step();
    chk_out("unit_lat.c2", 1, 5'd7, 64'h1234, 2'd0, 1, 0);
`endif
    step();
    chk_out("unit_lat.c3", 0, 5'd0, 64'h0, 2'd0, 1, 0);

    // Fill the queue behind a busy pipe; third result waits for a free slot.
    drive(0, 1, 5'd9, 64'h90, 1, 5'd1, 64'h11);
    step(); chk_out("fill.c0", 1, 5'd9, 64'h90, 2'd1, 1, 0);
    drive(0, 1, 5'd9, 64'h91, 1, 5'd2, 64'h12);
    step(); chk_out("fill.c1", 1, 5'd9, 64'h91, 2'd2, 0, 0);
    drive(0, 1, 5'd9, 64'h92, 1, 5'd3, 64'h13);
    step(); chk_out("fill.c2", 1, 5'd9, 64'h92, 2'd2, 0, 0);
    drive(0, 0, 5'd0, 64'h0, 1, 5'd3, 64'h13);
    step(); chk_out("fill.c3", 1, 5'd1, 64'h11, 2'd1, 1, 0);
    drive(0, 0, 5'd0, 64'h0, 1, 5'd3, 64'h13);
    step(); chk_out("fill.c4", 1, 5'd2, 64'h12, 2'd1, 1, 0);
    drive(0, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0);
    step(); chk_out("fill.c5", 1, 5'd3, 64'h13, 2'd0, 1, 0);
    step(); chk_out("fill.c6", 0, 5'd0, 64'h0, 2'd0, 1, 0);

    // Starvation: head waits behind a continuously writing pipe until a forced stall.
    drive(0, 1, 5'd8, 64'h80, 1, 5'd6, 64'h60);
    step(); chk_out("starve.c0", 1, 5'd8, 64'h80, 2'd1, 1, 0);
    drive(0, 1, 5'd8, 64'h80, 0, 5'd0, 64'h0);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk_out($sformatf("starve.c%0d", k), 1, 5'd8, 64'h80, 2'd1, 1, (k == 8) ? 1'b1 : 1'b0);
    end
    drive(0, 1, 5'd8, 64'h81, 0, 5'd0, 64'h0);
    step(); chk_out("starve.c9", 1, 5'd6, 64'h60, 2'd0, 1, 0);
    step(); chk_out("starve.c10", 1, 5'd8, 64'h81, 2'd0, 1, 0);
    drive(0, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0);
    step(); chk_out("starve.c11", 0, 5'd0, 64'h0, 2'd0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
